// File: rtl/store_gate_controller.sv
// Smart-store occupancy sequencer: edge-detects entry/exit pads, serves one request at a time,
// holds the matching gate open and enforces capacity. Optional pad filter: define DEBOUNCE_EN.
module store_gate_controller #(
  parameter int MAX_COUNT       = 20,
  parameter int DOOR_HOLD       = 4,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pressure_in,
  input  logic       pressure_out,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic       gate_in,
  output logic       gate_out,
  output logic       deny
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTER,
    S_EXIT
  } state_e;

  localparam int              HOLD_W    = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DOOR_HOLD - 1);
  localparam logic [4:0]      MAX_C     = 5'(MAX_COUNT);

  if (MAX_COUNT < 1 || MAX_COUNT > 31 || DOOR_HOLD < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("store_gate_controller: parameter out of range");
  end

  // Bit 0 is the entry direction, bit 1 the exit direction throughout.
  logic [1:0] pad;
  logic [1:0] lvl_q;
  logic [1:0] lvl_prev_q;
  logic [1:0] rise;

  assign pad = {pressure_out, pressure_in};

`ifdef DEBOUNCE_EN
  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q [2];

  // The filtered level flips only once the raw pad has disagreed with it for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pad[i] == lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          lvl_q[i]    <= pad[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end
`else
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) lvl_q <= '0;
    else       lvl_q <= pad;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) lvl_prev_q <= '0;
    else       lvl_prev_q <= lvl_q;
  end

  assign rise = lvl_q & ~lvl_prev_q;

  state_e            state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic [1:0]        pend_q,  pend_d;
  logic              deny_q,  deny_d;
  logic [1:0]        req;
  logic              exit_go;

  // Requests seen in IDLE include the same-cycle rise so latency stays at one edge.
  assign req     = pend_q | rise;
  assign exit_go = req[1] && (count_q != 5'd0);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hold_d  = hold_q;
    pend_d  = pend_q | rise;
    deny_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        hold_d = '0;
        if (req[1]) begin
          pend_d[1] = 1'b0;
          if (exit_go) begin
            state_d = S_EXIT;
            count_d = count_q - 5'd1;
          end
        end
        if (!exit_go && req[0]) begin
          pend_d[0] = 1'b0;
          if (count_q < MAX_C) begin
            state_d = S_ENTER;
            count_d = count_q + 5'd1;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      S_ENTER, S_EXIT: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hold_q  <= '0;
      pend_q  <= '0;
      deny_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      deny_q  <= deny_d;
    end
  end

  assign count    = count_q;
  assign full     = (count_q == MAX_C);
  assign empty    = (count_q == 5'd0);
  assign gate_in  = (state_q == S_ENTER);
  assign gate_out = (state_q == S_EXIT);
  assign deny     = deny_q;

endmodule

// File: tb/tb_store_gate_controller.sv
// Self-checking bench for store_gate_controller: a cycle-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations. Honours DEBOUNCE_EN if defined.
module tb_store_gate_controller;

  localparam int MAXC = 20;
  localparam int HOLD = 4;
  localparam int DB   = 3;
`ifdef DEBOUNCE_EN
  localparam int LAT = DB;
  localparam int PW  = 5;
`else
  localparam int LAT = 1;
  localparam int PW  = 2;
`endif
  localparam int GAP = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pressure_in = 1'b0;
  logic       pressure_out = 1'b0;
  logic [4:0] count;
  logic       full, empty, gate_in, gate_out, deny;

  int n_total = 0;
  int n_pass  = 0;

  store_gate_controller #(
    .MAX_COUNT(MAXC), .DOOR_HOLD(HOLD), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .pressure_in(pressure_in), .pressure_out(pressure_out),
    .count(count), .full(full), .empty(empty), .gate_in(gate_in), .gate_out(gate_out),
    .deny(deny)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_count = 0, m_busy = 0, m_dir = 0;  // m_dir: 1 = entry, 2 = exit
  bit m_pend_in, m_pend_out, m_deny;
  bit m_lvl_in, m_lvl_out, m_prev_in, m_prev_out;
  int m_run_in, m_run_out;

  function automatic void filt(input bit raw, inout bit lvl, inout int run);
`ifdef DEBOUNCE_EN
    if (raw != lvl) begin
      run++;
      if (run >= DB) begin
        lvl = raw;
        run = 0;
      end
    end else run = 0;
`else
    lvl = raw;
    run = 0;
`endif
  endfunction

  task automatic model_step();
    bit r_in, r_out, q_in, q_out, exit_taken;
    if (reset) begin
      m_count = 0; m_busy = 0; m_dir = 0; m_deny = 0;
      m_pend_in = 0; m_pend_out = 0;
      m_lvl_in = 0; m_lvl_out = 0; m_prev_in = 0; m_prev_out = 0;
      m_run_in = 0; m_run_out = 0;
      return;
    end
    r_in  = m_lvl_in  && !m_prev_in;
    r_out = m_lvl_out && !m_prev_out;
    m_prev_in  = m_lvl_in;
    m_prev_out = m_lvl_out;
    filt(pressure_in,  m_lvl_in,  m_run_in);
    filt(pressure_out, m_lvl_out, m_run_out);
    m_deny = 0;
    if (m_busy > 0) begin
      m_busy--;
      m_pend_in  |= r_in;
      m_pend_out |= r_out;
    end else begin
      q_in  = m_pend_in  | r_in;
      q_out = m_pend_out | r_out;
      m_pend_in = 0;
      m_pend_out = 0;
      exit_taken = 0;
      if (q_out && m_count > 0) begin
        m_count--; m_busy = HOLD; m_dir = 2; exit_taken = 1;
      end
      if (q_in) begin
        if (exit_taken) m_pend_in = 1;
        else if (m_count < MAXC) begin
          m_count++; m_busy = HOLD; m_dir = 1;
        end else m_deny = 1;
      end
    end
  endtask

  int gin_cyc = 0, gout_cyc = 0, deny_cyc = 0, overlap = 0;

  always begin
    @(posedge clk);
    model_step();
    #1;
    check("count",    int'(count),    m_count);
    check("full",     int'(full),     int'(m_count == MAXC));
    check("empty",    int'(empty),    int'(m_count == 0));
    check("gate_in",  int'(gate_in),  int'(m_busy > 0 && m_dir == 1));
    check("gate_out", int'(gate_out), int'(m_busy > 0 && m_dir == 2));
    check("deny",     int'(deny),     int'(m_deny));
    gin_cyc  += int'(gate_in);
    gout_cyc += int'(gate_out);
    deny_cyc += int'(deny);
    overlap  += int'(gate_in && gate_out);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit pin, input bit pout, input int len);
    @(negedge clk);
    pressure_in  = pin;
    pressure_out = pout;
    repeat (len) @(negedge clk);
    pressure_in  = 1'b0;
    pressure_out = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  int g0, d0, c0;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full),  0);
    check("rst_gates", int'({gate_in, gate_out, deny}), 0);

    // Three separate entries: count 1,2,3, gate_in open HOLD cycles each.
    for (int i = 1; i <= 3; i++) begin
      g0 = gin_cyc;
      pulse(1, 0, PW);
      wait_cycles(GAP);
      check("entry_count", int'(count), i);
      check("entry_gate_cycles", gin_cyc - g0, HOLD);
      if (i == 1) check("entry_empty_drop", int'(empty), 0);
    end

    // Simultaneous rises at count 3: exit first, entry after one IDLE cycle.
    @(negedge clk);
    pressure_in = 1'b1; pressure_out = 1'b1;
    @(posedge clk);
    repeat (LAT) @(posedge clk);
    #1;
    check("sim_exit_count", int'(count), 2);
    check("sim_exit_gate",  int'({gate_in, gate_out}), 1);
    @(negedge clk);
    pressure_in = 1'b0; pressure_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sim_exit_still_open", int'(gate_out), 1);
    @(posedge clk);
    #1;
    check("sim_idle_gap", int'({gate_in, gate_out}), 0);
    @(posedge clk);
    #1;
    check("sim_entry_gate",  int'({gate_in, gate_out}), 2);
    check("sim_entry_count", int'(count), 3);
    wait_cycles(GAP);

    // Fill to capacity, then a refused entry.
    for (int i = 0; i < MAXC - 3; i++) begin
      pulse(1, 0, PW);
      wait_cycles(GAP);
    end
    check("fill_count", int'(count), MAXC);
    check("fill_full",  int'(full), 1);
    g0 = gin_cyc; d0 = deny_cyc;
    pulse(1, 0, PW);
    wait_cycles(GAP);
    check("deny_pulses",    deny_cyc - d0, 1);
    check("deny_no_gate",   gin_cyc - g0, 0);
    check("deny_count",     int'(count), MAXC);
    check("deny_full",      int'(full), 1);

    // Reset mid-service with count 5 and an exit pending.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse(1, 0, PW);
      wait_cycles(GAP);
    end
    @(negedge clk);
    pressure_in = 1'b1;
    @(posedge clk);
    repeat (LAT) @(posedge clk);
    #1;
    check("mid_count5",  int'(count), 5);
    check("mid_gate_in", int'(gate_in), 1);
    @(negedge clk); pressure_in = 1'b0; pressure_out = 1'b1;
    @(negedge clk); pressure_out = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_gate",  int'(gate_in), 0);
    check("mid_rst_empty", int'(empty), 1);
    @(negedge clk); reset = 1'b0;
    g0 = gout_cyc;
    wait_cycles(GAP);
    check("mid_exit_discarded", gout_cyc - g0, 0);

    // Exit on an empty store does nothing.
    pulse(0, 1, PW);
    wait_cycles(GAP);
    check("empty_exit_gate",  gout_cyc - g0, 0);
    check("empty_exit_count", int'(count), 0);
    check("empty_exit_empty", int'(empty), 1);

    // Simultaneous rises at count 0: exit dropped, entry served on the same edge.
    @(negedge clk);
    pressure_in = 1'b1; pressure_out = 1'b1;
    @(posedge clk);
    repeat (LAT) @(posedge clk);
    #1;
    check("sim0_count", int'(count), 1);
    check("sim0_gates", int'({gate_in, gate_out}), 2);
    @(negedge clk);
    pressure_in = 1'b0; pressure_out = 1'b0;
    wait_cycles(GAP);

    // A pad held high is a single request.
    g0 = gin_cyc;
    pulse(1, 0, 20);
    wait_cycles(GAP);
    check("held_count", int'(count), 2);
    check("held_gate_cycles", gin_cyc - g0, HOLD);

`ifdef DEBOUNCE_EN
    // Short glitch ignored; long pulse counted exactly DB edges after first sample.
    c0 = int'(count);
    pulse(1, 0, 2);
    wait_cycles(GAP);
    check("db_glitch", int'(count), c0);
    @(negedge clk);
    pressure_in = 1'b1;
    repeat (DB) @(posedge clk);
    #1;
    check("db_before", int'(count), c0);
    @(posedge clk);
    #1;
    check("db_after", int'(count), c0 + 1);
    repeat (2) @(negedge clk);
    pressure_in = 1'b0;
    wait_cycles(GAP);
`endif

    check("gates_never_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
